// File: rtl/ifd_seq_gen.sv
// ---------------------------------------------------------------------------
// ifd_seq_gen
//   Instruction-issue sequencer for PDP-8 execution-unit benches. A DEPTH-entry
//   program table is written at runtime. On start, the sequencer plays entries
//   0..start_len-1 onto the memory-reference or op7 opcode port. It can stop
//   after one pass or wrap forever. Each issue waits for the execution unit's
//   stall handshake, keeps the opcode up for at least two cycles, and clears it
//   for at least one cycle before the next issue.
//
//   Entry format (23 bits):
//     [22]           kind: 0 = memory reference, 1 = op7
//     mem:  [ADDR_W+5:ADDR_W] one-hot opcode, [ADDR_W-1:0] operand address
//     op7:  [21:0]            one-hot op7 code
//   The opcode ports carry these fields flattened: pdp_mem_opcode = entry[ADDR_W+5:0]
//   and pdp_op7_opcode = entry[21:0].
//
//   Optional feature macro: STALL_TIMEOUT_EN. When defined, a stall watchdog
//   ends playback after TIMEOUT_CYCLES consecutive stalled cycles and sets a
//   sticky timeout_err.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   stall             execution unit not ready
//   PC_value          execution-unit PC, paged into base_addr at each issue
//   ld_en/addr/data   program table write port, honoured only while idle
//   start/start_len   begin playback of start_len entries (0 = ignored)
//   loop_en           sampled on start; wrap to entry 0 instead of stopping
//   abort             synchronous stop without a done pulse
//   base_addr         page base of PC_value captured at the last issue
//   pdp_mem_opcode    memory-reference opcode + address (0 when not issuing)
//   pdp_op7_opcode    op7 opcode (0 when not issuing)
//   busy, done        playback active / one-cycle normal-completion pulse
//   issue_cnt         opcodes issued since the last start (wraps)
//   timeout_err       sticky watchdog flag (tied 0 without STALL_TIMEOUT_EN)
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module ifd_seq_gen #(
    parameter int ADDR_W         = `ADDR_WIDTH,
    parameter int DEPTH          = 16,
    parameter int PAGE_BITS      = 7,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     stall,
    input  logic [ADDR_W-1:0]        PC_value,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [22:0]              ld_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   start_len,
    input  logic                     loop_en,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        base_addr,
    output logic [ADDR_W+5:0]        pdp_mem_opcode,
    output logic [21:0]              pdp_op7_opcode,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              issue_cnt,
    output logic                     timeout_err
);

    localparam int ENTRY_W = 23;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = IDX_W + 1;
    localparam logic [ADDR_W-1:0] PAGE_MASK = {ADDR_W{1'b1}} << PAGE_BITS;

    typedef enum logic [1:0] {IDLE, WAIT_RDY, ISSUE, HOLD} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d, next_ptr;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                loop_q, loop_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;      // table[ptr], fetched before WAIT_RDY
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [ADDR_W+5:0]   mem_q, mem_d;
    logic [21:0]         op7_q, op7_d;
    logic                done_q, done_d;
    logic [15:0]         issue_cnt_q, issue_cnt_d;
    logic                last_entry;

    logic [ENTRY_W-1:0]  table_mem [DEPTH];

`ifdef STALL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // NOTE: the table is storage, not control state, so it has no reset;
    // playback never reads an entry before software has loaded it.
    always_ff @(posedge clk) begin
        if (ld_en && state_q == IDLE) begin
            table_mem[ld_addr] <= ld_data;
        end
    end

    assign last_entry = ({1'b0, ptr_q} == len_q - LEN_W'(1));

    // NOTE: every *_d gets its hold value first so no path leaves a variable
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        loop_d      = loop_q;
        entry_d     = entry_q;
        base_addr_d = base_addr_q;
        mem_d       = mem_q;
        op7_d       = op7_q;
        done_d      = 1'b0;
        issue_cnt_d = issue_cnt_q;
        next_ptr    = ptr_q + 1'b1;
`ifdef STALL_TIMEOUT_EN
        wd_d          = '0;
        timeout_err_d = timeout_err_q;
`endif

        if (abort && state_q != IDLE) begin
            // Abort outranks every transition; counters and base stay frozen.
            state_d = IDLE;
            mem_d   = '0;
            op7_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && start_len != '0) begin
                        state_d     = WAIT_RDY;
                        len_d       = start_len;
                        loop_d      = loop_en;
                        ptr_d       = '0;
                        issue_cnt_d = '0;
                        // Fetching here gives write-after-read against a
                        // same-cycle table write to entry 0.
                        entry_d     = table_mem[0];
`ifdef STALL_TIMEOUT_EN
                        timeout_err_d = 1'b0;
`endif
                    end
                end
                WAIT_RDY: begin
                    if (!stall) begin
                        state_d = ISSUE;
                        if (entry_q[ENTRY_W-1]) begin
                            op7_d = entry_q[21:0];
                        end else begin
                            mem_d = entry_q[ADDR_W+5:0];
                        end
                        base_addr_d = PC_value & PAGE_MASK;
                        issue_cnt_d = issue_cnt_q + 16'd1;
                    end
                end
                ISSUE: begin
                    state_d = HOLD;
                end
                HOLD: begin
                    if (!stall) begin
                        mem_d = '0;
                        op7_d = '0;
                        if (last_entry && !loop_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_RDY;
                            ptr_d   = last_entry ? '0 : next_ptr;
                            entry_d = table_mem[last_entry ? '0 : next_ptr];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

`ifdef STALL_TIMEOUT_EN
            // Any stall==0 cycle or state change leaves wd_d at its 0 default.
            if ((state_q == WAIT_RDY || state_q == HOLD) && stall) begin
                if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = IDLE;
                    mem_d         = '0;
                    op7_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            entry_q     <= '0;
            base_addr_q <= '0;
            mem_q       <= '0;
            op7_q       <= '0;
            done_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            entry_q     <= entry_d;
            base_addr_q <= base_addr_d;
            mem_q       <= mem_d;
            op7_q       <= op7_d;
            done_q      <= done_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

`ifdef STALL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign base_addr      = base_addr_q;
    assign pdp_mem_opcode = mem_q;
    assign pdp_op7_opcode = op7_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign issue_cnt      = issue_cnt_q;

endmodule

// File: tb/tb_ifd_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_ifd_seq_gen
//   Self-checking bench for ifd_seq_gen (ADDR_W=12, DEPTH=16, PAGE_BITS=7,
//   TIMEOUT_CYCLES=16). The reference model is the program table as loaded
//   plus the playback rules: the k-th issue presents entry k mod len on the
//   port chosen by its kind, with the page base of the PC seen at that edge.
// ---------------------------------------------------------------------------
module tb_ifd_seq_gen;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic [11:0] PC_value;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [22:0] ld_data;
    logic        start;
    logic [4:0]  start_len;
    logic        loop_en;
    logic        abort;
    logic [11:0] base_addr;
    logic [17:0] pdp_mem_opcode;
    logic [21:0] pdp_op7_opcode;
    logic        busy;
    logic        done;
    logic [15:0] issue_cnt;
    logic        timeout_err;

    int n_pass  = 0;
    int n_check = 0;

    logic [22:0] tbl [16];   // reference copy of the program table

    ifd_seq_gen #(
        .ADDR_W(12), .DEPTH(16), .PAGE_BITS(7), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .PC_value(PC_value),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .start_len(start_len), .loop_en(loop_en), .abort(abort),
        .base_addr(base_addr), .pdp_mem_opcode(pdp_mem_opcode),
        .pdp_op7_opcode(pdp_op7_opcode), .busy(busy), .done(done),
        .issue_cnt(issue_cnt), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] mem_entry(input int code, input logic [11:0] addr);
        logic [5:0] oh;
        oh = 6'(1) << code;
        return {1'b0, 4'b0000, oh, addr};
    endfunction

    function automatic logic [22:0] op7_entry(input int bitpos);
        logic [21:0] oh;
        oh = 22'(1) << bitpos;
        return {1'b1, oh};
    endfunction

    function automatic logic [22:0] rand_entry();
        if ($urandom_range(1) == 1) return op7_entry($urandom_range(21));
        return mem_entry($urandom_range(5), 12'($urandom));
    endfunction

    function automatic logic [17:0] exp_mem(input logic [22:0] e);
        return e[22] ? 18'h0 : e[17:0];
    endfunction

    function automatic logic [21:0] exp_op7(input logic [22:0] e);
        return e[22] ? e[21:0] : 22'h0;
    endfunction

    task automatic load(input int idx, input logic [22:0] data);
        ld_en   = 1'b1;
        ld_addr = 4'(idx);
        ld_data = data;
        step();
        ld_en   = 1'b0;
        tbl[idx] = data;
    endtask

    // Start a playback and follow it to done (or to the abort after
    // abort_after issues). Issues are detected as opcode rising from all-zero.
    task automatic play(input string tag, input int len, input bit lp,
                        input int stall_pct, input int abort_after, input bit junk_ld);
        int          k;
        int          cyc;
        int          last_cyc;
        bit          prev_act;
        bit          act;
        bit          finished;
        logic [11:0] pc_drv;
        logic [22:0] e;

        start     = 1'b1;
        start_len = 5'(len);
        loop_en   = lp;
        step();
        start   = 1'b0;
        loop_en = 1'b0;
        check({tag, "/busy_on_start"}, busy, 1);
        check({tag, "/cnt_cleared"}, issue_cnt, 0);

        k = 0; cyc = 0; last_cyc = 0; prev_act = 0; finished = 0;
        while (!finished && cyc < 3000) begin
            stall    = ($urandom_range(99) < stall_pct);
            pc_drv   = 12'($urandom);
            PC_value = pc_drv;
            if (junk_ld) begin
                ld_en   = 1'($urandom_range(1));
                ld_addr = 4'($urandom);
                ld_data = 23'($urandom);
            end
            abort = (abort_after > 0 && k == abort_after);
            step();
            cyc  += 1;
            ld_en = 1'b0;
            act   = (pdp_mem_opcode != 0) || (pdp_op7_opcode != 0);
            if (abort) begin
                abort = 1'b0;
                check({tag, "/abort_busy"}, busy, 0);
                check({tag, "/abort_mem"}, pdp_mem_opcode, 0);
                check({tag, "/abort_op7"}, pdp_op7_opcode, 0);
                check({tag, "/abort_no_done"}, done, 0);
                check({tag, "/abort_cnt"}, issue_cnt, abort_after);
                finished = 1;
            end else begin
                if (act && !prev_act) begin
                    e = tbl[k % len];
                    check({tag, "/mem"}, pdp_mem_opcode, exp_mem(e));
                    check({tag, "/op7"}, pdp_op7_opcode, exp_op7(e));
                    check({tag, "/base"}, base_addr, pc_drv & 12'o7600);
                    check({tag, "/cnt"}, issue_cnt, k + 1);
                    if (stall_pct == 0) begin
                        check({tag, "/spacing"}, cyc - last_cyc, (k == 0) ? 1 : 3);
                    end
                    last_cyc = cyc;
                    k += 1;
                end
                if (done) begin
                    check({tag, "/done_issues"}, k, len);
                    check({tag, "/done_cnt"}, issue_cnt, len);
                    check({tag, "/done_idle"}, busy, 0);
                    if (stall_pct == 0) check({tag, "/done_cycle"}, cyc, 3 * len);
                    else                check({tag, "/done_min_cycles"}, cyc >= 3 * len, 1);
                    finished = 1;
                    step();
                    check({tag, "/done_pulse_width"}, done, 0);
                end
            end
            prev_act = act;
        end
        check({tag, "/ended_in_bound"}, finished, 1);
        stall = 1'b0;
    endtask

    initial begin
        logic [22:0] old_e;
        logic [22:0] new_e;
        int          len;

        reset_n = 1'b1; stall = 1'b0; PC_value = '0; ld_en = 1'b0; ld_addr = '0;
        ld_data = '0; start = 1'b0; start_len = '0; loop_en = 1'b0; abort = 1'b0;
        #3 reset_n = 1'b0;
        step();
        step();
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/mem", pdp_mem_opcode, 0);
        check("reset/op7", pdp_op7_opcode, 0);
        check("reset/base", base_addr, 0);
        check("reset/cnt", issue_cnt, 0);
        check("reset/timeout", timeout_err, 0);
        reset_n = 1'b1;
        step();

        // Twelve memory-reference entries, no stall: 3-cycle cadence, done at 36.
        for (int i = 0; i < 12; i++) load(i, mem_entry(i % 6, 12'(i + 1)));
        play("seq12", 12, 0, 0, 0, 0);

        // start_len of zero is ignored.
        start = 1'b1; start_len = '0;
        step();
        start = 1'b0;
        check("len0/busy", busy, 0);

        // op7 CLA_CLL held through five stalled HOLD cycles; PC paging.
        load(0, op7_entry(10));
        PC_value = 12'o1234;
        start = 1'b1; start_len = 5'd1;
        step();
        start = 1'b0;
        step();
        check("op7/visible", pdp_op7_opcode, 22'(1) << 10);
        check("op7/mem_zero", pdp_mem_opcode, 0);
        check("op7/base", base_addr, 12'o1200);
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("op7/held", pdp_op7_opcode, 22'(1) << 10);
            check("op7/held_mem_zero", pdp_mem_opcode, 0);
        end
        stall = 1'b0;
        step();
        check("op7/cleared", pdp_op7_opcode, 0);
        check("op7/done", done, 1);
        check("op7/base_held", base_addr, 12'o1200);

        // Looped playback of three entries, aborted after seven issues.
        for (int i = 0; i < 3; i++) load(i, rand_entry());
        play("loop3", 3, 1, 30, 7, 1);
        step();
        step();
        check("loop3/cnt_frozen", issue_cnt, 7);
        check("loop3/still_idle", busy, 0);

        // Randomized single-pass programs with random stall and ignored loads.
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(16, 1);
            for (int i = 0; i < len; i++) load(i, rand_entry());
            play("rand", len, 0, 40, 0, 1);
        end

        // Table write in the same cycle as start: first issue uses the old entry.
        old_e = mem_entry(3, 12'o0777);
        new_e = op7_entry(4);
        load(0, old_e);
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = new_e;
        start = 1'b1; start_len = 5'd1;
        step();
        ld_en = 1'b0; start = 1'b0;
        step();
        check("war/mem_old", pdp_mem_opcode, exp_mem(old_e));
        check("war/op7_old", pdp_op7_opcode, exp_op7(old_e));
        step();
        step();
        check("war/done", done, 1);
        tbl[0] = new_e;
        play("war_new", 1, 0, 0, 0, 0);

        // Asynchronous reset while an opcode is on the port, then replay.
        load(0, mem_entry(1, 12'o0042));
        load(1, op7_entry(0));
        start = 1'b1; start_len = 5'd2;
        step();
        start = 1'b0;
        step();
        check("rst_mid/issuing", pdp_mem_opcode, exp_mem(tbl[0]));
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid/busy", busy, 0);
        check("rst_mid/mem", pdp_mem_opcode, 0);
        check("rst_mid/op7", pdp_op7_opcode, 0);
        check("rst_mid/base", base_addr, 0);
        check("rst_mid/cnt", issue_cnt, 0);
        step();
        reset_n = 1'b1;
        step();
        play("rst_replay", 2, 0, 0, 0, 0);

`ifdef STALL_TIMEOUT_EN
        // Stall stuck high: watchdog fires on the 16th stalled cycle.
        stall = 1'b1;
        start = 1'b1; start_len = 5'd1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) check("wd/busy_before", busy, 1);
        end
        check("wd/timeout_err", timeout_err, 1);
        check("wd/busy", busy, 0);
        check("wd/mem", pdp_mem_opcode, 0);
        check("wd/op7", pdp_op7_opcode, 0);
        check("wd/no_done", done, 0);
        stall = 1'b0;
        play("wd_restart", 1, 0, 0, 0, 0);
        check("wd/cleared_by_start", timeout_err, 0);
`else
        // Without the watchdog a stuck stall waits indefinitely.
        stall = 1'b1;
        start = 1'b1; start_len = 5'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("nowd/busy", busy, 1);
        check("nowd/timeout_err", timeout_err, 0);
        check("nowd/op7", pdp_op7_opcode, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        stall = 1'b0;
        check("nowd/abort_idle", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
